// File: rtl/fetch_decode_exec.sv
// fetch_decode_exec: single-issue RV32I fetch/decode/execute with IF/ID register and registered writeback.
// Optional M_EXT_MUL_EN adds MUL (low 32 bits of rs1*rs2).
module fetch_decode_exec #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  output logic        pc_send_valid_o,
  input  logic        pc_receive_ready_i,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_data_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  output logic        rs1_req_rd_valid_o,
  output logic        rs2_req_rd_valid_o,
  input  logic [31:0] rs1_reg_data_i,
  input  logic [31:0] rs2_reg_data_i,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_req_wr_valid_o,
  input  logic        hold_flag_i,
  input  logic        div_busy_i
);
  logic        stall, accept;
  logic        pv_q, ok_q, wr_q;
  logic [31:0] inst_q, pc_q, data_q;
  logic [4:0]  addr_q;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_u, a, b, sra, alu, res;
  logic        is_op, is_imm, sub, supp;
  assign stall  = hold_flag_i | div_busy_i;
  assign accept = pv_q & pc_receive_ready_i & inst_valid_i & ~stall;
  assign opcode = inst_q[6:0];
  assign rd     = inst_q[11:7];
  assign funct3 = inst_q[14:12];
  assign funct7 = inst_q[31:25];
  assign imm_i  = {{20{inst_q[31]}}, inst_q[31:20]};
  assign imm_u  = {inst_q[31:12], 12'b0};
  assign is_op  = opcode == 7'b0110011;
  assign is_imm = opcode == 7'b0010011;
  assign rs1_addr_o = inst_q[19:15];
  assign rs2_addr_o = inst_q[24:20];
  assign rs1_req_rd_valid_o = ok_q & (is_op | is_imm);
  assign rs2_req_rd_valid_o = ok_q & is_op;
  assign a   = rs1_reg_data_i;
  assign b   = is_op ? rs2_reg_data_i : imm_i;
  // funct7[5] of an I-type is immediate bit 10, so only OP may subtract
  assign sub = is_op & funct7[5];
  assign sra = $signed(a) >>> b[4:0];
  always_comb begin
    alu = 32'b0;
    case (funct3)
      3'b000: alu = sub ? a - b : a + b;
      3'b001: alu = a << b[4:0];
      3'b010: alu = {31'b0, $signed(a) < $signed(b)};
      3'b011: alu = {31'b0, a < b};
      3'b100: alu = a ^ b;
      3'b101: alu = funct7[5] ? sra : a >> b[4:0];
      3'b110: alu = a | b;
      default: alu = a & b;
    endcase
  end
  always_comb begin
    res  = alu;
    supp = is_imm | (is_op & funct7[6] == 1'b0 & funct7[4:0] == 5'b0);
    if (opcode == 7'b0110111) begin
      res  = imm_u;
      supp = 1'b1;
    end else if (opcode == 7'b0010111) begin
      res  = pc_q + imm_u;
      supp = 1'b1;
    end
`ifdef M_EXT_MUL_EN
    if (is_op & funct7 == 7'b0000001 & funct3 == 3'b000) begin
      res  = a * rs2_reg_data_i;
      supp = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q   <= 1'b0;
      ok_q   <= 1'b0;
      inst_q <= NOP_INST;
      pc_q   <= 32'b0;
      wr_q   <= 1'b0;
      addr_q <= 5'b0;
      data_q <= 32'b0;
    end else begin
      pv_q <= ~stall;
      if (accept) begin
        inst_q <= inst_data_i;
        pc_q   <= pc_i;
        ok_q   <= 1'b1;
      end else if (!stall) ok_q <= 1'b0;
      wr_q <= ok_q & ~stall & supp & (rd != 5'b0);
      if (ok_q & ~stall & supp & (rd != 5'b0)) begin
        addr_q <= rd;
        data_q <= res;
      end
    end
  end
  assign pc_send_valid_o   = pv_q;
  assign rd_req_wr_valid_o = wr_q;
  assign rd_addr_o         = addr_q;
  assign rd_data_o         = data_q;
endmodule

// File: tb/tb_fetch_decode_exec.sv
// tb_fetch_decode_exec: directed vectors with hand-computed results for fetch_decode_exec.
module tb_fetch_decode_exec;
  logic        clk = 0, rst_n = 0;
  logic [31:0] pc_i = 0, inst_data_i = 0, rs1_reg_data_i = 0, rs2_reg_data_i = 0;
  logic        pc_receive_ready_i = 0, inst_valid_i = 0, hold_flag_i = 0, div_busy_i = 0;
  logic        pc_send_valid_o, rs1_req_rd_valid_o, rs2_req_rd_valid_o, rd_req_wr_valid_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [31:0] rd_data_o;
  int total = 0, bad = 0;
  logic [4:0]  exp_a = 0;
  logic [31:0] exp_d = 0;
  fetch_decode_exec dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .pc_send_valid_o(pc_send_valid_o),
    .pc_receive_ready_i(pc_receive_ready_i), .inst_valid_i(inst_valid_i), .inst_data_i(inst_data_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_req_rd_valid_o(rs1_req_rd_valid_o), .rs2_req_rd_valid_o(rs2_req_rd_valid_o),
    .rs1_reg_data_i(rs1_reg_data_i), .rs2_reg_data_i(rs2_reg_data_i),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_req_wr_valid_o(rd_req_wr_valid_o),
    .hold_flag_i(hold_flag_i), .div_busy_i(div_busy_i)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic exec(input string tag, input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2,
                      input logic we, input logic [4:0] ea, input logic [31:0] ed);
    inst_data_i = inst; rs1_reg_data_i = r1; rs2_reg_data_i = r2;
    inst_valid_i = 1; pc_receive_ready_i = 1;
    tick();
    inst_valid_i = 0; pc_receive_ready_i = 0;
    check({tag, "_lat"}, {31'b0, rd_req_wr_valid_o}, 0);
    tick();
    check({tag, "_wr"}, {31'b0, rd_req_wr_valid_o}, {31'b0, we});
    if (we) begin exp_a = ea; exp_d = ed; end
    check({tag, "_addr"}, {27'b0, rd_addr_o}, {27'b0, exp_a});
    check({tag, "_data"}, rd_data_o, exp_d);
    tick();
    check({tag, "_once"}, {31'b0, rd_req_wr_valid_o}, 0);
  endtask
  initial begin
    for (int i = 0; i < 9; i++) begin
      pc_i = $urandom; inst_data_i = $urandom; rs1_reg_data_i = $urandom; rs2_reg_data_i = $urandom;
      pc_receive_ready_i = 1'($urandom); inst_valid_i = 1'($urandom);
      hold_flag_i = 1'($urandom); div_busy_i = 1'($urandom);
      #10;
    end
    check("rst_pv", {31'b0, pc_send_valid_o}, 0);
    check("rst_wr", {31'b0, rd_req_wr_valid_o}, 0);
    check("rst_addr", {27'b0, rd_addr_o}, 0);
    check("rst_data", rd_data_o, 0);
    check("rst_rv", {30'b0, rs1_req_rd_valid_o, rs2_req_rd_valid_o}, 0);
    check("rst_rsaddr", {22'b0, rs1_addr_o, rs2_addr_o}, 0);
    pc_i = 32'h100; pc_receive_ready_i = 0; inst_valid_i = 0; hold_flag_i = 0; div_busy_i = 0;
    #2 rst_n = 1;
    tick();
    check("pv_after_rst", {31'b0, pc_send_valid_o}, 1);
    exec("addi", 32'h00500093, 0, 0, 1, 1, 5);
    inst_data_i = 32'h402081B3; rs1_reg_data_i = 3; rs2_reg_data_i = 5;
    inst_valid_i = 1; pc_receive_ready_i = 1;
    tick();
    inst_valid_i = 0; pc_receive_ready_i = 0;
    check("sub_rsaddr", {22'b0, rs1_addr_o, rs2_addr_o}, {22'b0, 5'd1, 5'd2});
    check("sub_rv", {30'b0, rs1_req_rd_valid_o, rs2_req_rd_valid_o}, 2'b11);
    tick();
    check("sub_wr", {31'b0, rd_req_wr_valid_o}, 1);
    check("sub_data", rd_data_o, 32'hFFFFFFFE);
    check("sub_addr", {27'b0, rd_addr_o}, 3);
    exp_a = 3; exp_d = 32'hFFFFFFFE;
    tick();
    check("sub_once", {31'b0, rd_req_wr_valid_o}, 0);
    exec("srai", 32'h4011D213, 32'h80000000, 0, 1, 4, 32'hC0000000);
    exec("auipc", 32'h00001397, 0, 0, 1, 7, 32'h00001100);
    exec("slt", 32'h0020A433, 32'hFFFFFFFF, 1, 1, 8, 1);
    exec("sltu", 32'h0020B433, 32'hFFFFFFFF, 1, 1, 8, 0);
    inst_data_i = 32'h123452B7; inst_valid_i = 1; pc_receive_ready_i = 1;
    tick();
    inst_valid_i = 0; pc_receive_ready_i = 0; hold_flag_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_wr", {31'b0, rd_req_wr_valid_o}, 0);
      check("hold_pv", {31'b0, pc_send_valid_o}, 0);
    end
    hold_flag_i = 0;
    tick();
    check("lui_wr", {31'b0, rd_req_wr_valid_o}, 1);
    check("lui_data", rd_data_o, 32'h12345000);
    check("lui_pv", {31'b0, pc_send_valid_o}, 1);
    exp_a = 5; exp_d = 32'h12345000;
    tick();
    check("lui_once", {31'b0, rd_req_wr_valid_o}, 0);
    exec("addi_x0", 32'h00100013, 0, 0, 0, 0, 0);
    exec("sys_op", 32'h000000F3, 0, 0, 0, 0, 0);
    inst_data_i = 32'h00500093; inst_valid_i = 0; pc_receive_ready_i = 1;
    tick();
    pc_receive_ready_i = 0;
    check("novalid_ok", {31'b0, rs1_req_rd_valid_o}, 0);
    tick();
    check("novalid_wr", {31'b0, rd_req_wr_valid_o}, 0);
    inst_data_i = 32'h00900093; inst_valid_i = 1; pc_receive_ready_i = 1;
    tick();
    inst_valid_i = 0; pc_receive_ready_i = 0; div_busy_i = 1;
    tick();
    check("busy_wr", {31'b0, rd_req_wr_valid_o}, 0);
    div_busy_i = 0;
    tick();
    check("busy_rel_wr", {31'b0, rd_req_wr_valid_o}, 1);
    check("busy_rel_data", rd_data_o, 9);
    exp_a = 1; exp_d = 9;
    tick();
`ifdef M_EXT_MUL_EN
    exec("mul", 32'h02208333, 7, 6, 1, 6, 42);
`else
    exec("mul", 32'h02208333, 7, 6, 0, 0, 0);
`endif
    inst_data_i = 32'h00500093; inst_valid_i = 1; pc_receive_ready_i = 1;
    tick();
    inst_valid_i = 0; pc_receive_ready_i = 0;
    #2 rst_n = 0;
    #1;
    check("mid_rst_pv", {31'b0, pc_send_valid_o}, 0);
    check("mid_rst_data", rd_data_o, 0);
    check("mid_rst_rv", {31'b0, rs1_req_rd_valid_o}, 0);
    #3 rst_n = 1;
    tick();
    check("mid_rst_nowr", {31'b0, rd_req_wr_valid_o}, 0);
    tick();
    check("mid_rst_nowr2", {31'b0, rd_req_wr_valid_o}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
